// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin sharing of one exact/approximate 32x32
// signed multiplier pair between N requesters, with per-request tag tracking.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready one-hot valid/ready handshake per requester
//   req_a/req_b         packed 32-bit signed operands, requester i at [32i+:32]
//   req_appx            per-request select: 1 = approximate product
//   mult_a/mult_b       registered operands to both external multipliers
//   mult_prod_exact/    products returned LATENCY cycles after the operands
//   mult_prod_appx
//   rsp_valid/rsp_id    one-cycle response pulse and owning requester
//   rsp_prod/rsp_err    selected product and (appx - exact) error
//   err_cnt/clr_cnt     saturating count of nonzero-error approximate responses
module mult_share_sched #(
    parameter int N       = 4,
    parameter int LATENCY = 0,
    localparam int ID_W   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*32-1:0] req_a,
    input  logic [N*32-1:0] req_b,
    input  logic [N-1:0]    req_appx,
    output logic [N-1:0]    req_ready,
    output logic [31:0]     mult_a,
    output logic [31:0]     mult_b,
    input  logic [63:0]     mult_prod_exact,
    input  logic [63:0]     mult_prod_appx,
    output logic            rsp_valid,
    output logic [ID_W-1:0] rsp_id,
    output logic [63:0]     rsp_prod,
    output logic [63:0]     rsp_err,
    output logic [15:0]     err_cnt,
    input  logic            clr_cnt
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] cand;
    logic [ID_W:0]   sum;
    logic [ID_W:0]   sum_nxt;
    logic            accept;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            sel_appx;

    logic [LATENCY:0]           tag_v;
    logic [LATENCY:0]           tag_appx;
    logic [LATENCY:0][ID_W-1:0] tag_id;

    logic            out_v;
    logic            out_appx;
    logic [ID_W-1:0] out_id;
    logic [63:0]     diff;

    // Scan from the highest offset down so the last hit is the first
    // valid requester at or after ptr.
    always_comb begin
        req_ready = '0;
        gnt_id    = '0;
        accept    = 1'b0;
        sum       = '0;
        cand      = '0;
        sum_nxt   = '0;
        ptr_nxt   = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_appx  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(N))
                sum = sum - (ID_W + 1)'(N);
            cand = sum[ID_W-1:0];
            if (req_valid[cand]) begin
                accept = 1'b1;
                gnt_id = cand;
            end
        end
        if (!rst_n)
            accept = 1'b0;
        if (accept)
            req_ready[gnt_id] = 1'b1;
        sum_nxt = {1'b0, gnt_id} + (ID_W + 1)'(1);
        if (sum_nxt >= (ID_W + 1)'(N))
            sum_nxt = '0;
        ptr_nxt = sum_nxt[ID_W-1:0];
        for (int k = 0; k < N; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_a    = req_a[32*k +: 32];
                sel_b    = req_b[32*k +: 32];
                sel_appx = req_appx[k];
            end
        end
    end

    // Tag pipe is LATENCY+1 deep: stage 0 lines up with mult_a/mult_b,
    // stage LATENCY lines up with the multiplier outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            tag_v    <= '0;
            tag_appx <= '0;
            tag_id   <= '0;
        end else begin
            if (accept) begin
                ptr    <= ptr_nxt;
                mult_a <= sel_a;
                mult_b <= sel_b;
            end
            tag_v[0]    <= accept;
            tag_appx[0] <= sel_appx;
            tag_id[0]   <= gnt_id;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_appx[i] <= tag_appx[i-1];
                tag_id[i]   <= tag_id[i-1];
            end
        end
    end

    assign out_v    = tag_v[LATENCY];
    assign out_appx = tag_appx[LATENCY];
    assign out_id   = tag_id[LATENCY];
    assign diff     = mult_prod_appx - mult_prod_exact;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_err   <= '0;
            err_cnt   <= '0;
        end else begin
            rsp_valid <= out_v;
            if (out_v) begin
                rsp_id   <= out_id;
                rsp_prod <= out_appx ? mult_prod_appx : mult_prod_exact;
                rsp_err  <= out_appx ? diff : 64'd0;
            end
            if (clr_cnt)
                err_cnt <= '0;
            else if (out_v && out_appx && (diff != 64'd0)
                     && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: directed checks of mult_share_sched with mock
// multipliers at LATENCY=0 (dut0) and LATENCY=2 (dut2) on shared stimulus.
module tb_mult_share_sched;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_appx;
    logic         clr_cnt;
    logic [63:0]  off;

    logic [3:0]  rdy0, rdy2;
    logic [31:0] ma0, mb0, ma2, mb2;
    logic [63:0] pe0, pa0, pe2, pa2;
    logic        rv0, rv2;
    logic [1:0]  rid0, rid2;
    logic [63:0] rp0, re0, rp2, re2;
    logic [15:0] ec0, ec2;
    logic [63:0] s1, s2;

    int checks;
    int failures;

    mult_share_sched #(.N(4), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_appx(req_appx), .req_ready(rdy0),
        .mult_a(ma0), .mult_b(mb0), .mult_prod_exact(pe0),
        .mult_prod_appx(pa0), .rsp_valid(rv0), .rsp_id(rid0),
        .rsp_prod(rp0), .rsp_err(re0), .err_cnt(ec0), .clr_cnt(clr_cnt)
    );

    mult_share_sched #(.N(4), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_appx(req_appx), .req_ready(rdy2),
        .mult_a(ma2), .mult_b(mb2), .mult_prod_exact(pe2),
        .mult_prod_appx(pa2), .rsp_valid(rv2), .rsp_id(rid2),
        .rsp_prod(rp2), .rsp_err(re2), .err_cnt(ec2), .clr_cnt(clr_cnt)
    );

    // Mock multipliers: low 64 bits of sign-extended operands.
    assign pe0 = {{32{ma0[31]}}, ma0} * {{32{mb0[31]}}, mb0};
    assign pa0 = pe0 + off;

    always_ff @(posedge clk) begin
        s1 <= {{32{ma2[31]}}, ma2} * {{32{mb2[31]}}, mb2};
        s2 <= s1;
    end
    assign pe2 = s2;
    assign pa2 = s2 + off;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        clr_cnt   = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'($urandom);
            req_appx  = 4'($urandom);
            req_a     = {$urandom, $urandom, $urandom, $urandom};
            req_b     = {$urandom, $urandom, $urandom, $urandom};
            clr_cnt   = 1'($urandom);
            #1;
            checks++;
            if ({rdy0, rdy2} !== 8'h00) begin
                failures++;
                $display("FAIL rst_ready got=%h exp=00", {rdy0, rdy2});
            end
            tick();
        end
        req_valid = '0;
        clr_cnt   = 1'b0;
        checks++;
        if ({ma0, mb0} !== 64'd0) begin
            failures++;
            $display("FAIL rst_mult got=%h exp=0", {ma0, mb0});
        end
        checks++;
        if ({rv0, rid0} !== 3'd0) begin
            failures++;
            $display("FAIL rst_rsp got=%h exp=0", {rv0, rid0});
        end
        checks++;
        if ({rp0, re0} !== 128'd0) begin
            failures++;
            $display("FAIL rst_prod_err got=%h exp=0", {rp0, re0});
        end
        checks++;
        if (ec0 !== 16'd0) begin
            failures++;
            $display("FAIL rst_errcnt got=%h exp=0", ec0);
        end
        checks++;
        if ({ma2, rv2, rid2, rp2, re2, ec2} !== '0) begin
            failures++;
            $display("FAIL rst_dut2 got=%h exp=0",
                     {ma2, rv2, rid2, rp2, re2, ec2});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({rv0, rv2} !== 2'b00) begin
                failures++;
                $display("FAIL rst_norsp cyc=%0d got=%b exp=00", i, {rv0, rv2});
            end
        end
    endtask

    task automatic test_single_exact();
        do_reset();
        off          = 64'd0;
        req_a[31:0]  = -32'd5793;
        req_b[31:0]  = 32'd3;
        req_appx     = 4'b0000;
        req_valid    = 4'b0001;
        #1;
        checks++;
        if (rdy0 !== 4'b0001) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0001", rdy0);
        end
        tick();
        req_valid = '0;
        checks++;
        if (rv0 !== 1'b0) begin
            failures++;
            $display("FAIL single_early got=%b exp=0", rv0);
        end
        tick();
        checks++;
        if ({rv0, rid0} !== 3'b100) begin
            failures++;
            $display("FAIL single_rsp got=%b exp=100", {rv0, rid0});
        end
        checks++;
        if (rp0 !== 64'hFFFF_FFFF_FFFF_BC1D) begin
            failures++;
            $display("FAIL single_prod got=%h exp=ffffffffffffbc1d", rp0);
        end
        checks++;
        if ({re0, ec0} !== 80'd0) begin
            failures++;
            $display("FAIL single_err got=%h exp=0", {re0, ec0});
        end
        tick();
        tick();
        checks++;
        if ({rv0, rv2, rp2} !== {2'b01, 64'hFFFF_FFFF_FFFF_BC1D}) begin
            failures++;
            $display("FAIL single_lat2 got=%b/%h exp=01/ffffffffffffbc1d",
                     {rv0, rv2}, rp2);
        end
    endtask

    task automatic test_round_robin();
        int r0;
        int r2;
        do_reset();
        off = 64'd0;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'(i + 1);
            req_b[32*i +: 32] = 32'd10;
        end
        req_appx = 4'b0000;
        for (int s = 0; s < 14; s++) begin
            req_valid = (s < 8) ? 4'hF : 4'h0;
            #1;
            checks++;
            if (rdy0 !== ((s < 8) ? 4'(1 << (s % 4)) : 4'h0)) begin
                failures++;
                $display("FAIL rr_grant s=%0d got=%b", s, rdy0);
            end
            r0 = s - 2;
            r2 = s - 4;
            checks++;
            if (rv0 !== (r0 >= 0 && r0 < 8)) begin
                failures++;
                $display("FAIL rr_valid0 s=%0d got=%b", s, rv0);
            end
            if (r0 >= 0 && r0 < 8) begin
                checks++;
                if (rid0 !== 2'(r0 % 4) || rp0 !== 64'((r0 % 4 + 1) * 10)) begin
                    failures++;
                    $display("FAIL rr_rsp0 s=%0d got=%0d/%0d exp=%0d/%0d",
                             s, rid0, rp0, r0 % 4, (r0 % 4 + 1) * 10);
                end
            end
            checks++;
            if (rv2 !== (r2 >= 0 && r2 < 8)) begin
                failures++;
                $display("FAIL rr_valid2 s=%0d got=%b", s, rv2);
            end
            if (r2 >= 0 && r2 < 8) begin
                checks++;
                if (rid2 !== 2'(r2 % 4) || rp2 !== 64'((r2 % 4 + 1) * 10)) begin
                    failures++;
                    $display("FAIL rr_rsp2 s=%0d got=%0d/%0d exp=%0d/%0d",
                             s, rid2, rp2, r2 % 4, (r2 % 4 + 1) * 10);
                end
            end
            tick();
        end
    endtask

    task automatic test_approx();
        do_reset();
        off           = 64'd5;
        req_a[95:64]  = -32'd5793;
        req_b[95:64]  = 32'hFFFF_FFFF;
        req_appx      = 4'b0100;
        req_valid     = 4'b0100;
        #1;
        checks++;
        if (rdy0 !== 4'b0100) begin
            failures++;
            $display("FAIL appx_ready got=%b exp=0100", rdy0);
        end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if ({rv0, rid0} !== 3'b110) begin
            failures++;
            $display("FAIL appx_rsp got=%b exp=110", {rv0, rid0});
        end
        checks++;
        if (rp0 !== 64'd5798 || re0 !== 64'd5) begin
            failures++;
            $display("FAIL appx_prod got=%0d/%0d exp=5798/5", rp0, re0);
        end
        checks++;
        if (ec0 !== 16'd1) begin
            failures++;
            $display("FAIL appx_cnt got=%0d exp=1", ec0);
        end
        tick();
        checks++;
        if (rv0 !== 1'b0) begin
            failures++;
            $display("FAIL appx_pulse got=%b exp=0", rv0);
        end
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        clr_cnt   = 1'b1;
        tick();
        checks++;
        if ({rv0, re0, ec0} !== {1'b1, 64'd5, 16'd0}) begin
            failures++;
            $display("FAIL appx_clr got=%b/%0d/%0d exp=1/5/0", rv0, re0, ec0);
        end
        tick();
        clr_cnt = 1'b0;
        checks++;
        if (ec0 !== 16'd0) begin
            failures++;
            $display("FAIL appx_clr_hold got=%0d exp=0", ec0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        off          = 64'd5;
        req_a[95:64] = 32'd7;
        req_b[95:64] = 32'd9;
        req_appx     = 4'b0100;
        req_valid    = 4'b0100;
        for (int i = 1; i <= 65600; i++) begin
            tick();
            if (i == 65535) begin
                checks++;
                if (ec0 !== 16'hFFFE) begin
                    failures++;
                    $display("FAIL sat_pre got=%h exp=fffe", ec0);
                end
            end
            if (i == 65536) begin
                checks++;
                if (ec0 !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL sat_hit got=%h exp=ffff", ec0);
                end
            end
        end
        req_valid = '0;
        tick();
        tick();
        tick();
        checks++;
        if ({ec0, ec2} !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h/%h exp=ffff/ffff", ec0, ec2);
        end
    endtask

    task automatic test_midflight_reset();
        do_reset();
        off      = 64'd0;
        req_appx = 4'b0000;
        for (int s = 0; s < 3; s++) begin
            req_valid = 4'hF;
            #1;
            checks++;
            if (rdy2 !== 4'(1 << s)) begin
                failures++;
                $display("FAIL mid_grant s=%0d got=%b", s, rdy2);
            end
            tick();
        end
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (rdy2 !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rst_ready got=%b exp=0000", rdy2);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (rdy2 !== 4'b0010) begin
            failures++;
            $display("FAIL mid_ptr got=%b exp=0010", rdy2);
        end
        req_valid = '0;
        checks++;
        if ({rv0, rv2} !== 2'b00) begin
            failures++;
            $display("FAIL mid_norsp0 got=%b exp=00", {rv0, rv2});
        end
        for (int i = 1; i < 7; i++) begin
            tick();
            checks++;
            if ({rv0, rv2} !== 2'b00) begin
                failures++;
                $display("FAIL mid_norsp cyc=%0d got=%b exp=00", i, {rv0, rv2});
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_appx  = '0;
        clr_cnt   = 1'b0;
        off       = 64'd0;
        test_reset();
        test_single_exact();
        test_round_robin();
        test_approx();
        test_saturation();
        test_midflight_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Round-robin scheduler that shares one 32x32 signed multiplier pair between N requesters. The pair is an exact unit and an approximate unit, both fed the same operands. The block accepts operand pairs over valid/ready, issues at most one per cycle, and tracks in-flight tags through the multiplier's fixed latency. It returns the exact or approximate product per request, plus the approximation error and a saturating error counter for run-time accuracy monitoring.

## Interface
- N, 4, number of requesters (2..8); ID_W = clog2(N)
- LATENCY, 0, register stages inside the external multipliers (0 = combinational)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  N  request valid, one bit per requester
- req_a  in  N*32  signed multiplicand; requester i uses bits [32i+31:32i]
- req_b  in  N*32  signed multiplier, same packing
- req_appx  in  N  1 = return approximate product, 0 = exact
- req_ready  out  N  one-hot grant; request i accepted on an edge where req_valid[i] & req_ready[i]
- mult_a  out  32  operand to both multipliers (registered)
- mult_b  out  32  operand to both multipliers (registered)
- mult_prod_exact  in  64  exact product, valid LATENCY cycles after mult_a/mult_b
- mult_prod_appx  in  64  approximate product, same timing
- rsp_valid  out  1  response valid, single-cycle pulse per request
- rsp_id  out  ID_W  index of the requester owning the response
- rsp_prod  out  64  selected product
- rsp_err  out  64  appx − exact when appx selected, else 0
- err_cnt  out  16  count of approximate responses with nonzero error
- clr_cnt  in  1  synchronous clear of err_cnt

## Operation
- Arbitration: pointer ptr (ID_W bits, reset 0). The grant goes to the first i with req_valid[i], searching ptr, ptr+1, … mod N.
- req_ready is combinational from req_valid and ptr. At most one bit is set. All bits are 0 when no request is pending.
- On acceptance of requester g: ptr <= (g+1) mod N, and mult_a/mult_b <= req_a[g]/req_b[g].
- On acceptance, the tag {id=g, appx=req_appx[g]} enters a LATENCY+1 deep tag shift register with a valid bit.
- Cycles with no acceptance: mult_a/mult_b hold their previous value, ptr holds, and an invalid slot enters the tag pipe.
- Response stage, registered: when the tag pipe output is valid, rsp_valid <= 1 and rsp_id <= tag id.
  - rsp_prod <= appx ? mult_prod_appx : mult_prod_exact.
  - rsp_err <= appx ? (mult_prod_appx − mult_prod_exact) : 0. This is 64-bit two's-complement subtraction that wraps, with no saturation.
- When the tag pipe output is invalid: rsp_valid <= 0, and rsp_id/rsp_prod/rsp_err hold.
- Responses carry no backpressure. Each requester must consume its response in the rsp_valid cycle.
- err_cnt:
  - Increments by 1 on each response with appx=1 and rsp_err≠0.
  - Saturates at 0xFFFF.
  - clr_cnt=1 forces err_cnt to 0 and takes priority over a coincident increment.
- Requesters hold req_a/req_b/req_appx stable while req_valid is high and not yet accepted. Changing them before acceptance is unsupported.

## Timing
- Reset values (rst_n low at an edge):
  - req_ready = 0 while rst_n low; ptr = 0.
  - mult_a = mult_b = 0; tag pipe all invalid.
  - rsp_valid = 0; rsp_id = 0; rsp_prod = 0; rsp_err = 0; err_cnt = 0.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is produced for requests accepted before reset.
- Latency: a request accepted at edge E0 produces rsp_valid high in the cycle following edge E0+LATENCY+1.
- Throughput: one acceptance per cycle. Under full load each requester is granted once every N cycles.
- With LATENCY=0 and requests every cycle, rsp_valid stays high continuously, and rsp_id repeats the grant sequence shifted by 1 cycle.
- Simultaneous events:
  - Acceptance and response in the same cycle are independent.
  - A response increment and clr_cnt in the same cycle give err_cnt=0.

## Test plan
- Reset: hold rst_n low 3 cycles with random inputs. Required: every output at its reset value, req_ready=0, and no rsp_valid within LATENCY+3 cycles after release.
- Single exact request, LATENCY=0: requester 0 with a=−5793, b=3, appx=0. Required: rsp_valid one cycle after the acceptance edge, rsp_id=0, rsp_prod=0xFFFFFFFFFFFFBC1D (−17379), rsp_err=0, err_cnt=0.
- Round-robin: all four req_valid held high for 8 cycles. Required: grants 0,1,2,3,0,1,2,3; one acceptance per cycle; rsp_id follows the same order delayed by LATENCY+1.
  - Repeat with LATENCY=2.
- Approximate path: mock approximate multiplier returns exact+5; requester 2 sends a=−5793, b=−1, appx=1. Required: rsp_prod=5798, rsp_err=5, err_cnt increments by 1.
  - Repeat the same request with clr_cnt high in the response cycle. Required: err_cnt=0.
- Saturation: drive 65537 approximate responses with nonzero error. Required: err_cnt reaches 0xFFFF and holds there.
- Reset mid-flight, LATENCY=2: accept 3 requests, then pulse rst_n low for 1 cycle before their responses. Required: no rsp_valid for those requests, ptr=0, and the next grant goes to the lowest-index valid requester.
